// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
// Holds the FSM state enum, register offsets and STATUS bit indices.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } rx_state_e;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int RXV  = 0;
  localparam int OVR  = 1;
  localparam int FERR = 2;
  localparam int PERR = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy count.
// Ports: clk, rst (sync, high), push/wdata, pop, head (current
// entry, combinational), full, empty. A push into a full FIFO is
// ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Bus-attached 8N1 UART receiver feeding an RX FIFO.
// Ports: clk, rst (sync, high), rxd (async serial in), cen/wr/addr
// slave port, rdata (XLEN, comb), error (comb, on writes).
// Option macro UART_RX_PARITY_EN adds an even-parity bit.
`ifndef XLEN
`define XLEN 32
`endif

module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic             cen,
  input  logic             wr,
  input  logic             addr,
  output logic [`XLEN-1:0] rdata,
  output logic             error
);

  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1;
  logic          rxs;
  rx_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tick;
  logic          push_ok;
  logic          ferr_set;
  logic          perr_set;
  logic          drop;
  logic          ovr_set;
  logic          ovr_q, ferr_q, perr_q;
  logic          rd, data_rd, stat_rd;
  logic          pop;
  logic [7:0]    head;
  logic          full, empty;

  // Two-flop synchroniser; idles high so reset
  // never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic pbad, pbad_n;
  assign drop = pbad;
`else
  assign drop = 1'b0;
`endif

  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      pbad  <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
`ifdef UART_RX_PARITY_EN
      pbad  <= pbad_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    push_ok  = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_n   = pbad;
`endif
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = HALF_CNT;
        end
      end
      START: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else if (rxs) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          cnt_n   = FULL_CNT;
          idx_n   = '0;
`ifdef UART_RX_PARITY_EN
          pbad_n  = 1'b0;
`endif
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else begin
          shreg_n = {rxs, shreg[7:1]};
          cnt_n   = FULL_CNT;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else begin
          cnt_n   = FULL_CNT;
          state_n = STOP;
          if (rxs != ^shreg) begin
            perr_set = 1'b1;
            pbad_n   = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else if (rxs) begin
          push_ok = ~drop;
          state_n = IDLE;
        end else begin
          ferr_set = 1'b1;
          state_n  = BRK;
        end
      end
      BRK: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign rd      = cen & ~wr;
  assign data_rd = rd & (addr == ADDR_DATA);
  assign stat_rd = rd & (addr == ADDR_STATUS);
  assign pop     = data_rd & ~empty;
  assign ovr_set = push_ok & full & ~pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .wdata (shreg),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Reading STATUS clears sticky flags; a set in the
  // same cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ovr_q  <= (ovr_q  & ~stat_rd) | ovr_set;
      ferr_q <= (ferr_q & ~stat_rd) | ferr_set;
      perr_q <= (perr_q & ~stat_rd) | perr_set;
    end
  end

  always_comb begin
    rdata = '0;
    error = 1'b0;
    unique case (1'b1)
      data_rd: begin
        if (!empty) rdata[7:0] = head;
      end
      stat_rd: begin
        rdata[RXV]  = ~empty;
        rdata[OVR]  = ovr_q;
        rdata[FERR] = ferr_q;
        rdata[PERR] = perr_q;
      end
      (cen & wr): error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx.
// CLKS_PER_BIT=16, FIFO_DEPTH=8.
`ifndef XLEN
`define XLEN 32
`endif

module tb_uart_rx;

  localparam int CPB = 16;

  logic             clk;
  logic             rst;
  logic             rxd;
  logic             cen;
  logic             wr;
  logic             addr;
  logic [`XLEN-1:0] rdata;
  logic             error;

  int n_tests;
  int n_fail;

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .cen   (cen),
    .wr    (wr),
    .addr  (addr),
    .rdata (rdata),
    .error (error)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    rxd = v;
    wait_clks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^b);
`endif
    bit_out(stop);
    rxd = 1'b1;
    wait_clks(4);
  endtask

  task automatic rd_reg(input logic a,
                        output logic [`XLEN-1:0] d,
                        output logic e);
    cen  = 1'b1;
    wr   = 1'b0;
    addr = a;
    #2;
    d = rdata;
    e = error;
    wait_clks(1);
    cen = 1'b0;
  endtask

  task automatic wr_reg(input logic a, output logic e);
    cen  = 1'b1;
    wr   = 1'b1;
    addr = a;
    #2;
    e = error;
    wait_clks(1);
    cen = 1'b0;
    wr  = 1'b0;
  endtask

  task automatic test_reset;
    logic [`XLEN-1:0] d;
    logic e;
    rst = 1'b1;
    wait_clks(3);
    n_tests++;
    if (rdata !== '0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_bus: rdata=%0h error=%0b want 0/0",
               rdata, error);
    end
    rst = 1'b0;
    wait_clks(4);
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(0)) begin
      n_fail++;
      $display("FAIL reset_status: got %0h want 0", d);
    end
    rd_reg(1'b0, d, e);
    n_tests++;
    if (d !== `XLEN'(0) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_data_read: got %0h err %0b want 0/0", d, e);
    end
  endtask

  task automatic test_single;
    logic [`XLEN-1:0] d;
    logic e;
    send_frame(8'hA5, 1'b1);
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(1)) begin
      n_fail++;
      $display("FAIL single_status: got %0h want 1", d);
    end
    rd_reg(1'b0, d, e);
    n_tests++;
    if (d !== `XLEN'(8'hA5) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL single_data: got %0h err %0b want a5/0", d, e);
    end
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(0)) begin
      n_fail++;
      $display("FAIL single_status_after: got %0h want 0", d);
    end
  endtask

  task automatic test_overflow;
    logic [`XLEN-1:0] d;
    logic e;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1);
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(3)) begin
      n_fail++;
      $display("FAIL ovr_status: got %0h want 3", d);
    end
    for (int i = 0; i < 8; i++) begin
      rd_reg(1'b0, d, e);
      n_tests++;
      if (d !== `XLEN'(i)) begin
        n_fail++;
        $display("FAIL ovr_data%0d: got %0h want %0h", i, d, i);
      end
    end
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(0)) begin
      n_fail++;
      $display("FAIL ovr_status_after: got %0h want 0", d);
    end
  endtask

  task automatic test_break;
    logic [`XLEN-1:0] d;
    logic e;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(8'h3C >> i);
`ifdef UART_RX_PARITY_EN
    bit_out(^8'h3C);
`endif
    bit_out(1'b0);
    wait_clks(40);
    rxd = 1'b1;
    wait_clks(8);
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(4)) begin
      n_fail++;
      $display("FAIL ferr_status: got %0h want 4", d);
    end
    send_frame(8'h11, 1'b1);
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(1)) begin
      n_fail++;
      $display("FAIL brk_next_status: got %0h want 1", d);
    end
    rd_reg(1'b0, d, e);
    n_tests++;
    if (d !== `XLEN'(8'h11)) begin
      n_fail++;
      $display("FAIL brk_next_data: got %0h want 11", d);
    end
  endtask

  task automatic test_glitch_and_write;
    logic [`XLEN-1:0] d;
    logic e;
    rxd = 1'b0;
    wait_clks(4);
    rxd = 1'b1;
    wait_clks(30);
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(0)) begin
      n_fail++;
      $display("FAIL glitch_status: got %0h want 0", d);
    end
    send_frame(8'h5A, 1'b1);
    wr_reg(1'b0, e);
    n_tests++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL write_data_err: got %0b want 1", e);
    end
    wr_reg(1'b1, e);
    n_tests++;
    if (e !== 1'b1) begin
      n_fail++;
      $display("FAIL write_status_err: got %0b want 1", e);
    end
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(1) || e !== 1'b0) begin
      n_fail++;
      $display("FAIL write_status_kept: got %0h err %0b want 1/0", d, e);
    end
    rd_reg(1'b0, d, e);
    n_tests++;
    if (d !== `XLEN'(8'h5A)) begin
      n_fail++;
      $display("FAIL write_data_kept: got %0h want 5a", d);
    end
  endtask

  task automatic test_reset_midframe;
    logic [`XLEN-1:0] d;
    logic e;
    send_frame(8'h55, 1'b1);
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    rxd = 1'b1;
    wait_clks(8);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    wait_clks(30);
    send_frame(8'h42, 1'b1);
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(1)) begin
      n_fail++;
      $display("FAIL rst_mid_status: got %0h want 1", d);
    end
    rd_reg(1'b0, d, e);
    n_tests++;
    if (d !== `XLEN'(8'h42)) begin
      n_fail++;
      $display("FAIL rst_mid_data: got %0h want 42", d);
    end
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(0)) begin
      n_fail++;
      $display("FAIL rst_mid_empty: got %0h want 0", d);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_p(input logic [7:0] b, input logic p);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(p);
    bit_out(1'b1);
    rxd = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_parity;
    logic [`XLEN-1:0] d;
    logic e;
    send_frame_p(8'h01, 1'b0);
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(8)) begin
      n_fail++;
      $display("FAIL perr_status: got %0h want 8", d);
    end
    send_frame_p(8'h01, 1'b1);
    rd_reg(1'b1, d, e);
    n_tests++;
    if (d !== `XLEN'(1)) begin
      n_fail++;
      $display("FAIL par_ok_status: got %0h want 1", d);
    end
    rd_reg(1'b0, d, e);
    n_tests++;
    if (d !== `XLEN'(1)) begin
      n_fail++;
      $display("FAIL par_ok_data: got %0h want 1", d);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk  = 1'b0;
    rst  = 1'b1;
    rxd  = 1'b1;
    cen  = 1'b0;
    wr   = 1'b0;
    addr = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_break();
    test_glitch_and_write();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
